// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a two-flop input synchroniser and a first-word-fall-through
// byte FIFO drained by a valid/ready consumer; sticky frame and overflow flags.
module uart_rx_buffered #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 1_000_000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          serial_in,
  output logic [7:0]                    data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_error,
  output logic                          overflow,
  input  logic                          clear_errors
);

  localparam int CLOCKS_PER_BAUD = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF            = CLOCKS_PER_BAUD / 2;
  localparam int CNT_W           = $clog2(CLOCKS_PER_BAUD);
  localparam int AW              = $clog2(FIFO_DEPTH);
  localparam int FC_W            = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Input synchroniser
  logic r_sync_meta;
  logic r_rx_s;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= 1'b1;
      r_rx_s      <= 1'b1;
    end else begin
      r_sync_meta <= serial_in;
      r_rx_s      <= r_sync_meta;
    end
  end

  // Deframing FSM
  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]         r_bit, w_bit_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic               w_push;
  logic               w_fe_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_fe_set    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = S_START;
      end

      S_START: begin
        if (r_cnt == CNT_W'(HALF)) begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (r_cnt == CNT_W'(CLOCKS_PER_BAUD - 1)) begin
          w_cnt_nxt            = '0;
          w_shift_nxt[r_bit]   = r_rx_s;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (r_cnt == CNT_W'(CLOCKS_PER_BAUD - 1)) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_fe_set    = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_BREAK: begin
        w_cnt_nxt = '0;
        if (r_rx_s) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FWFT FIFO: head entry is always presented on data_out
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [FC_W-1:0] r_count;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_en;
  logic            w_ovf_set;

  assign w_full    = (r_count == FC_W'(FIFO_DEPTH));
  assign w_pop     = (r_count != '0) & data_out_ready;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  // NOTE: the storage array is reset because data_out must read 0 out of reset;
  // without that requirement the array would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set event outranks a coincident clear
  logic r_frame_error;
  logic r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_error <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_error <= w_fe_set  | (r_frame_error & ~clear_errors);
      r_overflow    <= w_ovf_set | (r_overflow    & ~clear_errors);
    end
  end

  assign data_out       = r_mem[r_rd_ptr];
  assign data_out_valid = (r_count != '0);
  assign fifo_count     = r_count;
  assign frame_error    = r_frame_error;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: queue-based FIFO/flag model fed by the
// character driver, compared every cycle, plus directed literal checks.
module tb_uart_rx_buffered;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int DEPTH    = 8;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  // Edges from the start-bit fall to the stop-bit decision: 2 synchroniser stages,
  // 1 start detect, HALF+1 start qualification, then 9 full bit periods.
  localparam int PUSH_LAT = HALF + 4 + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic [3:0] fifo_count;
  logic       frame_error;
  logic       overflow;
  logic       clear_errors;

  uart_rx_buffered #(
    .CPU_CLOCK_FREQ(CLK_FREQ),
    .BAUD_RATE     (BAUD),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .fifo_count    (fifo_count),
    .frame_error   (frame_error),
    .overflow      (overflow),
    .clear_errors  (clear_errors)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         stop_ok;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] m_q[$];
  bit         m_fe;
  bit         m_ov;
  int         cyc = 0;
  int         g_start;
  int         n_valid;
  logic [7:0] last_data;

  always @(posedge clk or negedge rst_n) begin
    ev_t ev;
    bit  hit, pop, fe_set, ov_set;
    int  sz;
    if (!rst_n) begin
      m_q.delete();
      pend.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
    end else begin
      cyc++;
      hit = 1'b0; fe_set = 1'b0; ov_set = 1'b0;
      if (pend.size() > 0 && pend[0].cyc == cyc) begin
        ev  = pend.pop_front();
        hit = 1'b1;
      end
      sz  = m_q.size();
      pop = (sz > 0) && data_out_ready;
      if (pop) void'(m_q.pop_front());
      if (hit) begin
        if (!ev.stop_ok)              fe_set = 1'b1;
        else if (sz < DEPTH || pop)   m_q.push_back(ev.data);
        else                          ov_set = 1'b1;
      end
      m_fe = fe_set | (m_fe & !clear_errors);
      m_ov = ov_set | (m_ov & !clear_errors);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", data_out_valid, m_q.size() != 0);
      check("count", fifo_count, m_q.size());
      check("frame_error", frame_error, m_fe);
      check("overflow", overflow, m_ov);
      if (m_q.size() != 0) check("data_out", data_out, m_q[0]);
      if (data_out_valid) begin
        n_valid++;
        last_data = data_out;
      end
    end
  end

  // Stimulus helpers; all callers stay aligned 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_char(input logic [7:0] b, input bit stop_ok, input int limit);
    logic [9:0] frame;
    ev_t        ev;
    int         n;
    frame   = {stop_ok, b, 1'b0};
    n       = 0;
    g_start = cyc;
    if (limit < 0) begin
      ev.cyc     = cyc + PUSH_LAT;
      ev.data    = b;
      ev.stop_ok = stop_ok;
      pend.push_back(ev);
    end
    for (int i = 0; i < 10; i++) begin
      serial_in = frame[i];
      for (int j = 0; j < CPB; j++) begin
        if (limit >= 0 && n == limit) return;
        @(posedge clk);
        #1;
        n++;
      end
    end
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    idle(1);
    clear_errors = 1'b0;
    idle(1);
  endtask

  bit done;

  initial begin
    rst_n          = 1'b0;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    clear_errors   = 1'b0;
    #35;
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_data", data_out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle line
    idle(100);
    check("idle_valid", data_out_valid, 1'b0);
    check("idle_count", fifo_count, 4'd0);
    check("idle_fe", frame_error, 1'b0);
    check("idle_ov", overflow, 1'b0);

    // Single character consumed immediately
    data_out_ready = 1'b1;
    n_valid = 0;
    send_char(8'h61, 1'b1, -1);
    idle(10);
    check("single_pulses", n_valid, 1);
    check("single_data", last_data, 8'h61);
    check("single_count", fifo_count, 4'd0);

    // Back-to-back burst into a stalled consumer
    data_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_char(8'h61 + i, 1'b1, -1);
    idle(10);
    check("burst_count", fifo_count, 4'd8);
    check("burst_ov", overflow, 1'b1);
    data_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("burst_order", data_out, 8'h61 + i);
      @(posedge clk);
      #1;
    end
    data_out_ready = 1'b0;
    check("burst_empty", fifo_count, 4'd0);
    pulse_clear();
    check("burst_ov_clr", overflow, 1'b0);

    // Short glitch is rejected; a following character still decodes
    serial_in = 1'b0;
    idle(10);
    serial_in = 1'b1;
    idle(100);
    check("glitch_count", fifo_count, 4'd0);
    check("glitch_fe", frame_error, 1'b0);
    data_out_ready = 1'b1;
    n_valid = 0;
    send_char(8'h3C, 1'b1, -1);
    idle(10);
    check("glitch_next", last_data, 8'h3C);
    check("glitch_pulses", n_valid, 1);

    // Framing error then a good character
    data_out_ready = 1'b0;
    send_char(8'h55, 1'b0, -1);
    serial_in = 1'b1;
    idle(2 * CPB);
    send_char(8'hA3, 1'b1, -1);
    idle(10);
    check("fe_set", frame_error, 1'b1);
    check("fe_count", fifo_count, 4'd1);
    check("fe_head", data_out, 8'hA3);
    data_out_ready = 1'b1;
    idle(1);
    data_out_ready = 1'b0;
    pulse_clear();
    check("fe_clr", frame_error, 1'b0);

    // Full FIFO: push coincident with pop
    for (int i = 0; i < 8; i++) send_char(8'h10 + i, 1'b1, -1);
    fork
      send_char(8'h18, 1'b1, -1);
      begin
        int k;
        int target;
        #1;
        target = g_start + PUSH_LAT;
        k = 0;
        while (cyc != target - 1 && k < 2 * PUSH_LAT) begin
          @(posedge clk);
          #1;
          k++;
        end
        check("sync_wait", k < 2 * PUSH_LAT, 1'b1);
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
      end
    join
    idle(10);
    check("fullpp_count", fifo_count, 4'd8);
    check("fullpp_ov", overflow, 1'b0);
    data_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fullpp_order", data_out, 8'h11 + i);
      @(posedge clk);
      #1;
    end
    data_out_ready = 1'b0;

    // Randomized traffic with random consumer stalls and clears
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          bit ok;
          ok = ($urandom_range(0, 6) != 0);
          send_char(8'($urandom), ok, -1);
          serial_in = 1'b1;
          if (!ok) idle(CPB + $urandom_range(0, CPB));
          else if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3 * CPB));
        end
        idle(20);
        done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!done && k < 50_000) begin
          @(posedge clk);
          #1;
          k++;
          if (!done) begin
            data_out_ready = (cyc > g_start + 2 * CPB && k > 6000) ?
                             ($urandom_range(0, 1) != 0) : ($urandom_range(0, 40) == 0);
            clear_errors   = ($urandom_range(0, 150) == 0);
          end
        end
        check("rand_bound", k < 50_000, 1'b1);
        clear_errors = 1'b0;
      end
    join
    data_out_ready = 1'b1;
    idle(20);
    data_out_ready = 1'b0;
    pulse_clear();

    // Asynchronous reset in the middle of a character
    send_char(8'h21, 1'b1, -1);
    send_char(8'h22, 1'b0, -1);
    serial_in = 1'b1;
    idle(2 * CPB);
    check("pre_rst_fe", frame_error, 1'b1);
    check("pre_rst_count", fifo_count, 4'd1);
    send_char(8'hC3, 1'b1, 4 * CPB);
    #5;
    rst_n = 1'b0;
    #1;
    check("arst_valid", data_out_valid, 1'b0);
    check("arst_count", fifo_count, 4'd0);
    check("arst_data", data_out, 8'h00);
    check("arst_fe", frame_error, 1'b0);
    check("arst_ov", overflow, 1'b0);
    serial_in = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    data_out_ready = 1'b1;
    n_valid = 0;
    send_char(8'h5A, 1'b1, -1);
    idle(10);
    check("post_rst_data", last_data, 8'h5A);
    check("post_rst_pulses", n_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
